// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle shared by the four bus masters and the round-robin arbiter.
// The master side drives requests, strobes and slave ready; the arbiter (slave side) drives grants and status.
interface bus_arbiter_rr_if;
  logic [3:0] mReq_;
  logic [3:0] mAs_;
  logic       sRdy_;
  logic [3:0] mGrnt_;
  logic [1:0] owner;
  logic       ownerValid;
  logic       busErr;
  logic [1:0] errMaster;

  modport master (
    output mReq_, mAs_, sRdy_,
    input  mGrnt_, owner, ownerValid, busErr, errMaster
  );

  modport slave (
    input  mReq_, mAs_, sRdy_,
    output mGrnt_, owner, ownerValid, busErr, errMaster
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with a hung-transaction watchdog and optional hold-limit preemption.
// Grants are active low and registered; a timeout drops the grant and pulses busErr for one cycle.
module bus_arbiter_rr #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned HOLD_W   = 8
) (
  input logic             clk,
  input logic             reset_,
  bus_arbiter_rr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    ERR
  } state_t;

  // Returns {found, index}: first requester strictly after last, wrapping around.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        owner_q, owner_d;
  logic              valid_q, valid_d;
  logic [3:0]        grnt_q, grnt_d;
  logic              bus_err_q, bus_err_d;
  logic [1:0]        err_master_q, err_master_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [3:0] req;
  logic [3:0] others;
  logic       owner_req;
  logic       owner_as;
  logic       stalled;
  logic       to_limit;
  logic       hold_sat;
  logic       hold_expired;
  logic [2:0] pick_any;
  logic [2:0] pick_oth;
  logic       take;
  logic [1:0] take_idx;

  always_comb begin
    req          = ~bus.mReq_;
    others       = req & ~(4'b0001 << owner_q);
    owner_req    = req[owner_q];
    owner_as     = ~bus.mAs_[owner_q];
    stalled      = owner_as & bus.sRdy_;
    to_limit     = (32'(to_cnt_q) == (TIMEOUT - 1));
    hold_sat     = &hold_cnt_q;
    hold_expired = (MAX_HOLD != 0) && (32'(hold_cnt_q) >= MAX_HOLD);
    pick_any     = rr_pick(req, last_q);
    pick_oth     = rr_pick(others, last_q);
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    valid_d      = valid_q;
    grnt_d       = grnt_q;
    bus_err_d    = 1'b0;
    err_master_d = err_master_q;
    to_cnt_d     = to_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    take         = 1'b0;
    take_idx     = 2'd0;

    case (state_q)
      IDLE: begin
        if (pick_any[2]) begin
          take     = 1'b1;
          take_idx = pick_any[1:0];
          state_d  = OWN;
        end
      end
      OWN: begin
        if (!owner_req) begin
          if (pick_oth[2]) begin
            take     = 1'b1;
            take_idx = pick_oth[1:0];
          end else begin
            state_d  = IDLE;
            grnt_d   = 4'b1111;
            valid_d  = 1'b0;
            to_cnt_d = '0;
          end
        end else if (stalled && to_limit) begin
          state_d      = ERR;
          grnt_d       = 4'b1111;
          valid_d      = 1'b0;
          bus_err_d    = 1'b1;
          err_master_d = owner_q;
          last_d       = owner_q;
          to_cnt_d     = '0;
        end else if (hold_expired && !owner_as && pick_oth[2]) begin
          // Preemption only between transactions, never with the strobe low.
          take     = 1'b1;
          take_idx = pick_oth[1:0];
        end else begin
          to_cnt_d   = stalled ? to_cnt_q + 1'b1 : '0;
          hold_cnt_d = hold_sat ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      grnt_d     = ~(4'b0001 << take_idx);
      owner_d    = take_idx;
      valid_d    = 1'b1;
      last_d     = take_idx;
      to_cnt_d   = '0;
      hold_cnt_d = '0;
    end
  end

  // Pointer resets to 3 so master 0 is first in line after reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= IDLE;
      last_q       <= 2'd3;
      owner_q      <= 2'd0;
      valid_q      <= 1'b0;
      grnt_q       <= 4'b1111;
      bus_err_q    <= 1'b0;
      err_master_q <= 2'd0;
      to_cnt_q     <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      valid_q      <= valid_d;
      grnt_q       <= grnt_d;
      bus_err_q    <= bus_err_d;
      err_master_q <= err_master_d;
      to_cnt_q     <= to_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bus.mGrnt_     = grnt_q;
  assign bus.owner      = owner_q;
  assign bus.ownerValid = valid_q;
  assign bus.busErr     = bus_err_q;
  assign bus.errMaster  = err_master_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model of owner / last-served / stall / hold bookkeeping.
module tb_bus_arbiter_rr;
  localparam int TIMEOUT  = 4;
  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 8;

  logic clk    = 1'b0;
  logic reset_ = 1'b1;

  always #5 clk = ~clk;

  bus_arbiter_rr_if bus ();

  bus_arbiter_rr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (8),
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (HOLD_W)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: m_owner = -1 means nobody holds the bus.
  int         m_owner;
  int         m_last;
  int         m_stall;
  int         m_held;
  bit         m_in_err;
  logic [3:0] exp_grnt;
  logic [1:0] exp_owner;
  logic [1:0] exp_errm;
  logic       exp_valid;
  logic       exp_err;

  function automatic int pick(logic [3:0] want, int start);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (want[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_owner   = -1;
    m_last    = 3;
    m_stall   = 0;
    m_held    = 0;
    m_in_err  = 1'b0;
    exp_grnt  = 4'b1111;
    exp_owner = 2'd0;
    exp_errm  = 2'd0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic modelGrant(int w);
    m_owner   = w;
    m_last    = w;
    m_stall   = 0;
    m_held    = 0;
    exp_owner = 2'(w);
  endtask

  task automatic modelStep(logic [3:0] req_n, logic [3:0] as_n, logic rdy_n);
    logic [3:0] want;
    int         w;
    int         o;
    bit         stalled;
    want    = ~req_n;
    exp_err = 1'b0;
    if (m_in_err) begin
      m_in_err = 1'b0;
    end else if (m_owner < 0) begin
      w = pick(want, m_last);
      if (w >= 0) modelGrant(w);
    end else begin
      o       = m_owner;
      stalled = !as_n[o] && rdy_n;
      w       = pick(want & ~(4'b0001 << o), m_last);
      if (req_n[o]) begin
        if (w >= 0) modelGrant(w);
        else m_owner = -1;
      end else if (stalled && m_stall == TIMEOUT - 1) begin
        exp_err  = 1'b1;
        exp_errm = 2'(o);
        m_last   = o;
        m_owner  = -1;
        m_in_err = 1'b1;
      end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && as_n[o] && w >= 0) begin
        modelGrant(w);
      end else begin
        m_stall = stalled ? m_stall + 1 : 0;
        if (m_held < (2 ** HOLD_W) - 1) m_held++;
      end
    end
    exp_valid = (m_owner >= 0);
    exp_grnt  = (m_owner >= 0) ? ~(4'b0001 << m_owner) : 4'b1111;
  endtask

  task automatic compare(string tag, logic [3:0] observed, logic [3:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(string tag);
    compare({tag, " mGrnt_"},     bus.mGrnt_,               exp_grnt);
    compare({tag, " ownerValid"}, {3'b000, bus.ownerValid}, {3'b000, exp_valid});
    compare({tag, " owner"},      {2'b00, bus.owner},       {2'b00, exp_owner});
    compare({tag, " busErr"},     {3'b000, bus.busErr},     {3'b000, exp_err});
    compare({tag, " errMaster"},  {2'b00, bus.errMaster},   {2'b00, exp_errm});
  endtask

  task automatic applyStimulus(logic [3:0] req_n, logic [3:0] as_n, logic rdy_n);
    @(negedge clk);
    bus.mReq_ = req_n;
    bus.mAs_  = as_n;
    bus.sRdy_ = rdy_n;
    @(posedge clk);
    if (reset_) modelStep(req_n, as_n, rdy_n);
    #1;
  endtask

  task automatic cycle(string tag, logic [3:0] req_n, logic [3:0] as_n, logic rdy_n);
    applyStimulus(req_n, as_n, rdy_n);
    checkOutput(tag);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic pulseReset();
    @(negedge clk);
    #2 reset_ = 1'b0;
    modelReset();
    #1;
    compare("async reset mGrnt_", bus.mGrnt_, 4'b1111);
    compare("async reset ownerValid", {3'b000, bus.ownerValid}, 4'b0000);
    checkOutput("async reset");
    @(posedge clk);
    #1 checkOutput("held in reset");
    #3 reset_ = 1'b1;
  endtask

  initial begin
    int         dut_cur;
    int         cnt;
    int         gaps;
    int         seq[$];
    int         exp_order[5];
    logic [3:0] rq;
    logic [3:0] as_r;
    logic       rdy_r;

    exp_order = '{0, 1, 2, 3, 0};
    bus.mReq_ = 4'b1111;
    bus.mAs_  = 4'b1111;
    bus.sRdy_ = 1'b1;
    modelReset();
    #1 reset_ = 1'b0;
    #1 checkOutput("reset");
    compare("reset mGrnt_ const", bus.mGrnt_, 4'b1111);
    @(negedge clk);
    reset_ = 1'b1;

    repeat (10) cycle("idle", 4'b1111, 4'b1111, 1'b1);
    compare("idle mGrnt_ const", bus.mGrnt_, 4'b1111);

    // Single request from master 2, held then released.
    cycle("req2", 4'b1011, 4'b1111, 1'b1);
    compare("req2 mGrnt_ const", bus.mGrnt_, 4'b1011);
    compare("req2 owner const", {2'b00, bus.owner}, 4'd2);
    repeat (4) cycle("hold2", 4'b1011, 4'b1111, 1'b1);
    cycle("rel2", 4'b1111, 4'b1111, 1'b1);
    compare("rel2 mGrnt_ const", bus.mGrnt_, 4'b1111);

    // Round robin with direct handovers.
    pulseReset();
    dut_cur = -1;
    cnt     = 0;
    gaps    = 0;
    for (int n = 0; n < 60 && seq.size() < 5; n++) begin
      rq = 4'b0000;
      if (m_owner >= 0 && cnt >= 3) rq[m_owner] = 1'b1;
      cycle("rr", rq, 4'b1111, 1'b1);
      if (dut_cur >= 0 && bus.ownerValid !== 1'b1) gaps++;
      if (bus.ownerValid === 1'b1 && int'(bus.owner) != dut_cur) begin
        seq.push_back(int'(bus.owner));
        dut_cur = int'(bus.owner);
      end
      if (m_owner >= 0 && cnt >= 1 && rq == 4'b0000) cnt++;
      else cnt = 1;
    end
    compare("rr grants seen", 4'(seq.size()), 4'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      compare($sformatf("rr order %0d", i), 4'(seq[i]), 4'(exp_order[i]));
    end
    compare("rr idle gaps", 4'(gaps), 4'd0);

    // Watchdog: master 1 stalls with master 2 waiting.
    cycle("to idle", 4'b1111, 4'b1111, 1'b1);
    cycle("to grant1", 4'b1101, 4'b1111, 1'b1);
    compare("to grant1 const", bus.mGrnt_, 4'b1101);
    repeat (3) cycle("stall", 4'b1001, 4'b1101, 1'b1);
    compare("stall3 busErr const", {3'b000, bus.busErr}, 4'b0000);
    cycle("stall4", 4'b1001, 4'b1101, 1'b1);
    compare("timeout busErr const", {3'b000, bus.busErr}, 4'b0001);
    compare("timeout errMaster const", {2'b00, bus.errMaster}, 4'd1);
    compare("timeout mGrnt_ const", bus.mGrnt_, 4'b1111);
    cycle("err cycle", 4'b1001, 4'b1111, 1'b1);
    compare("err pulse ends", {3'b000, bus.busErr}, 4'b0000);
    cycle("after err", 4'b1001, 4'b1111, 1'b1);
    compare("after err mGrnt_ const", bus.mGrnt_, 4'b1011);

    // Hold-limit preemption with the strobe idle.
    cycle("pre idle", 4'b1111, 4'b1111, 1'b1);
    cycle("pre grant0", 4'b1110, 4'b1111, 1'b1);
    compare("pre grant0 const", bus.mGrnt_, 4'b1110);
    for (int n = 0; n < 30 && m_owner != 3; n++) cycle("pre wait", 4'b0110, 4'b1111, 1'b1);
    compare("preempt mGrnt_ const", bus.mGrnt_, 4'b0111);

    // No preemption while a transaction is in flight.
    cycle("busy idle", 4'b1111, 4'b1111, 1'b1);
    cycle("busy grant0", 4'b1110, 4'b1111, 1'b1);
    repeat (15) cycle("busy hold", 4'b0110, 4'b1110, 1'b0);
    compare("busy no preempt const", bus.mGrnt_, 4'b1110);
    cycle("busy done", 4'b0110, 4'b1111, 1'b0);
    compare("busy preempt const", bus.mGrnt_, 4'b0111);

    // Reset in the middle of a stalled transaction.
    cycle("rst idle", 4'b1111, 4'b1111, 1'b1);
    cycle("rst grant2", 4'b1011, 4'b1111, 1'b1);
    repeat (2) cycle("rst stall", 4'b1011, 4'b1011, 1'b1);
    pulseReset();
    cycle("post reset", 4'b0000, 4'b1111, 1'b1);
    compare("post reset first const", bus.mGrnt_, 4'b1110);

    // Random traffic, requests and ready biased so timeouts and handovers both occur.
    for (int n = 0; n < 400; n++) begin
      rq    = 4'($urandom) & 4'($urandom);
      as_r  = 4'($urandom);
      rdy_r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) pulseReset();
      cycle("random", rq, as_r, rdy_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion by 100000 ns, expected bench to finish");
    $fatal(1, "[TB] time limit expired");
  end

endmodule
